// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
// mem_bus_responder : memory end of the L2 line bus (latency + fixed burst).
// Optional macro ACCESS_STATS_EN enables the rd_cnt/wr_cnt burst counters.
// Revision: 1.0
// ============================================================================
module mem_bus_responder #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              addrstb,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stb,
  output logic              busy,
  output logic [7:0]        drop_cnt,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [DEPTH_LOG2-1:0] LINE_MASK = DEPTH_LOG2'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [WAIT_W-1:0]     WAIT_INIT = (LATENCY > 0) ? WAIT_W'(LATENCY - 1) : '0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  we_q, we_d;
  logic [DEPTH_LOG2-1:0] base_q, base_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [7:0]            drop_q, drop_d;

  logic [DATA_W-1:0]     mem [DEPTH];

  logic                  accept;
  logic                  last_beat;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  unused_addr;

  assign req_idx     = addr[3 +: DEPTH_LOG2];
  assign unused_addr = ^{addr[2:0], addr >> (DEPTH_LOG2 + 3)};
  assign accept      = (state_q == S_IDLE) && addrstb;
  assign last_beat   = (state_q == S_BURST) && (beat_q == LAST_BEAT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (addrstb) state_d = (LATENCY > 0) ? S_WAIT : S_BURST;
      S_WAIT:  if (wait_q == '0) state_d = S_BURST;
      S_BURST: if (beat_q == LAST_BEAT) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state flop so that reset drops them at once
  always_comb begin
    stb  = (state_q == S_BURST);
    busy = (state_q != S_IDLE);
  end

  // Request context, latency counter, beat counter and read pipeline
  always_comb begin
    we_d   = accept ? we : we_q;
    base_d = accept ? (req_idx & ~LINE_MASK) : base_q;
    wait_d = wait_q;
    if (accept) begin
      wait_d = WAIT_INIT;
    end else if ((state_q == S_WAIT) && (wait_q != '0)) begin
      wait_d = wait_q - 1'b1;
    end
    beat_d = (state_q == S_BURST) ? beat_q + 1'b1 : '0;
    // Fetch the beat one cycle early so rdata is registered when stb rises
    rd_idx  = base_d + DEPTH_LOG2'(beat_d);
    rdata_d = rdata_q;
    if ((state_d == S_BURST) && !we_d) begin
      rdata_d = mem[rd_idx];
    end
    drop_d = drop_q;
    if (addrstb && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      base_q  <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      rdata_q <= '0;
      drop_q  <= '0;
    end else begin
      we_q    <= we_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      drop_q  <= drop_d;
    end
  end

  assign wr_idx = base_q + DEPTH_LOG2'(beat_q);

  // Array contents survive reset; only beats actually strobed are written
  always_ff @(posedge clk) begin
    if ((state_q == S_BURST) && we_q) begin
      mem[wr_idx] <= wdata;
    end
  end

  assign rdata    = rdata_q;
  assign drop_cnt = drop_q;

`ifdef ACCESS_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (last_beat) begin
      if (we_q) wr_cnt_d = wr_cnt_q + 16'd1;
      else      rd_cnt_d = rd_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  logic unused_last;
  assign unused_last = last_beat;
  assign rd_cnt      = '0;
  assign wr_cnt      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
`default_nettype none
// ============================================================================
// tb_mem_bus_responder : table-driven directed bench for mem_bus_responder.
// Revision: 1.0
// ============================================================================
module tb_mem_bus_responder;

  typedef struct {
    logic             we;
    logic [31:0]      addr;
    logic [3:0][63:0] wd;
    logic [3:0][63:0] rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        addrstb = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0;

  logic [63:0] rdata0, rdata1, rdata2;
  logic        stb0, stb1, stb2;
  logic        busy0, busy1, busy2;
  logic [7:0]  drop0, unused_drop1, unused_drop2;
  logic [15:0] rdc0, wrc0;
  logic [15:0] unused_rdc1, unused_wrc1, unused_rdc2, unused_wrc2;

  int n_chk = 0;
  int n_fail = 0;
  int sel = 0;
  int exp_drop = 0;

  logic        m_stb, m_busy;
  logic [63:0] m_rdata;

  always #5 clk = ~clk;

  mem_bus_responder dut (
    .clk(clk), .rst_n(rst_n), .addrstb(addrstb), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .stb(stb0), .busy(busy0), .drop_cnt(drop0), .rd_cnt(rdc0), .wr_cnt(wrc0)
  );

  mem_bus_responder #(.LATENCY(0)) dut_l0 (
    .clk(clk), .rst_n(rst_n), .addrstb(addrstb), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .stb(stb1), .busy(busy1), .drop_cnt(unused_drop1),
    .rd_cnt(unused_rdc1), .wr_cnt(unused_wrc1)
  );

  mem_bus_responder #(.DEPTH_LOG2(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .addrstb(addrstb), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata2), .stb(stb2), .busy(busy2), .drop_cnt(unused_drop2),
    .rd_cnt(unused_rdc2), .wr_cnt(unused_wrc2)
  );

  always_comb begin
    m_stb   = stb0;
    m_busy  = busy0;
    m_rdata = rdata0;
    if (sel == 1) begin
      m_stb = stb1; m_busy = busy1; m_rdata = rdata1;
    end else if (sel == 2) begin
      m_stb = stb2; m_busy = busy2; m_rdata = rdata2;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge of the first idle cycle.
  task automatic run_vec(input vec_t v, input bit hammer);
    bit ok;
    int lat;
    ok  = 1'b1;
    lat = (sel == 1) ? 0 : 4;
    addrstb = 1'b1; we = v.we; addr = v.addr;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      addrstb = hammer; we = ~v.we; addr = ~v.addr;
      if (m_stb || !m_busy) ok = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      addrstb = hammer; we = ~v.we; addr = ~v.addr;
      if (!m_stb || !m_busy) ok = 1'b0;
      if (v.we) wdata = v.wd[k];
      else      chk($sformatf("rdata_beat%0d", k), m_rdata, v.rd[k]);
    end
    @(negedge clk);
    addrstb = 1'b0;
    if (m_stb || m_busy) ok = 1'b0;
    if (!v.we) chk("rdata_hold", m_rdata, v.rd[3]);
    chk("stb_busy_window", 64'(ok), 64'd1);
  endtask

  vec_t tbl [7];
  vec_t v;

  localparam logic [63:0] P1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] P2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] P3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] P4 = 64'h4444_4444_4444_4444;

  initial begin
    tbl[0] = '{1'b1, 32'h0000_0040, {P4, P3, P2, P1}, '0};
    tbl[1] = '{1'b0, 32'h0000_0048, '0, {P4, P3, P2, P1}};
    tbl[2] = '{1'b1, 32'h0000_0100, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
                                     64'h0123_4567_89AB_CDEF, 64'hA5A5_A5A5_A5A5_A5A5}, '0};
    tbl[3] = '{1'b0, 32'h0000_0118, '0, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
                                         64'h0123_4567_89AB_CDEF, 64'hA5A5_A5A5_A5A5_A5A5}};
    tbl[4] = '{1'b0, 32'h0000_005F, '0, {P4, P3, P2, P1}};
    tbl[5] = '{1'b1, 32'h0000_1FE0, {64'hD3, 64'hD2, 64'hD1, 64'hD0}, '0};
    tbl[6] = '{1'b0, 32'h0000_3FE8, '0, {64'hD3, 64'hD2, 64'hD1, 64'hD0}};

    repeat (2) @(negedge clk);
    chk("reset_stb", 64'(stb0), 64'd0);
    chk("reset_busy", 64'(busy0), 64'd0);
    chk("reset_rdata", rdata0, 64'd0);
    chk("reset_drop", 64'(drop0), 64'd0);
    chk("reset_rd_cnt", 64'(rdc0), 64'd0);
    chk("reset_wr_cnt", 64'(wrc0), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back table at minimum spacing on the default instance
    sel = 0;
    for (int i = 0; i < 7; i++) run_vec(tbl[i], 1'b0);
    chk("no_false_drop", 64'(drop0), 64'd0);

    // Zero-latency instance: write, then read back with first beat next cycle
    sel = 1;
    v = '{1'b1, 32'h0000_0800, {64'hC3, 64'hC2, 64'hC1, 64'hC0}, '0};
    run_vec(v, 1'b0);
    repeat (4) @(negedge clk);
    v.we = 1'b0; v.rd = v.wd;
    run_vec(v, 1'b0);
    repeat (4) @(negedge clk);

    // 16-word instance: line at index 12..15 must not spill into word 0
    sel = 2;
    v = '{1'b1, 32'h0000_0000, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, '0};
    run_vec(v, 1'b0);
    v = '{1'b1, 32'h0000_0078, {64'hB3, 64'hB2, 64'hB1, 64'hB0}, '0};
    run_vec(v, 1'b0);
    v = '{1'b0, 32'h0000_0060, '0, {64'hB3, 64'hB2, 64'hB1, 64'hB0}};
    run_vec(v, 1'b0);
    v = '{1'b0, 32'h0000_0080, '0, {64'hA3, 64'hA2, 64'hA1, 64'hA0}};
    run_vec(v, 1'b0);

    // Strobe every busy cycle: transfers intact, drop count saturates
    sel = 0;
    chk("drop_before_hammer", 64'(drop0), 64'd0);
    for (int i = 0; i < 38; i++) begin
      run_vec(tbl[(i % 2 == 0) ? 1 : 3], 1'b1);
      exp_drop = (exp_drop + 8 > 255) ? 255 : exp_drop + 8;
      chk("drop_cnt", 64'(drop0), 64'(exp_drop));
    end

    // Reset during beat 2 of a write to base 0
    v = '{1'b1, 32'h0000_0000, {64'hE3, 64'hE2, 64'hE1, 64'hE0}, '0};
    run_vec(v, 1'b0);
    addrstb = 1'b1; we = 1'b1; addr = 32'h0;
    repeat (4) begin
      @(negedge clk);
      addrstb = 1'b0;
    end
    @(negedge clk); wdata = 64'hF0;
    chk("mid_write_stb", 64'(stb0), 64'd1);
    @(negedge clk); wdata = 64'hF1;
    @(negedge clk); wdata = 64'hF2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_stb", 64'(stb0), 64'd0);
    chk("async_rst_busy", 64'(busy0), 64'd0);
    @(negedge clk);
    chk("rst_rdata", rdata0, 64'd0);
    chk("rst_drop", 64'(drop0), 64'd0);
    chk("rst_rd_cnt", 64'(rdc0), 64'd0);
    chk("rst_wr_cnt", 64'(wrc0), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    v = '{1'b0, 32'h0000_0000, '0, {64'hE3, 64'hE2, 64'hF1, 64'hF0}};
    run_vec(v, 1'b0);

    // Completed-burst statistics: 3 writes, 2 reads since reset
    v = '{1'b1, 32'h0000_0200, {64'h73, 64'h72, 64'h71, 64'h70}, '0};
    run_vec(v, 1'b0);
    v.addr = 32'h0000_0240; run_vec(v, 1'b0);
    v.addr = 32'h0000_0280; run_vec(v, 1'b0);
    v = '{1'b0, 32'h0000_0240, '0, {64'h73, 64'h72, 64'h71, 64'h70}};
    run_vec(v, 1'b0);
`ifdef ACCESS_STATS_EN
    chk("rd_cnt", 64'(rdc0), 64'd2);
    chk("wr_cnt", 64'(wrc0), 64'd3);
`else
    chk("rd_cnt", 64'(rdc0), 64'd0);
    chk("wr_cnt", 64'(wrc0), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
